// File: rtl/array_mask_1r1w_ext.sv
// array_mask_1r1w_ext: masked 1-write/1-read SRAM model with 1- or 2-cycle
// registered read, hold-last read data and a defined collision policy.
//
// Ports:
//   clock, reset_n            single rising-edge clock, async active-low reset
//   W0_en/addr/mask/data      write port, per-lane mask of MASK_GRAN bits
//   R0_en/addr                read request, sampled at the rising edge
//   R0_data/R0_valid          read result (held) and one-cycle retire pulse
//
// Build option: define ARRAY_BYPASS_EN for write-first collisions;
// otherwise a same-address read and write return the pre-write contents.
module array_mask_1r1w_ext #(
    parameter int DEPTH     = 8,
    parameter int WIDTH     = 30,
    parameter int MASK_GRAN = 15,
    parameter int READ_LAT  = 1,
    localparam int MASK_SEG = WIDTH / MASK_GRAN,
    localparam int ADDR_W   = (DEPTH > 2) ? $clog2(DEPTH) : 1
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                W0_en,
    input  logic [ADDR_W-1:0]   W0_addr,
    input  logic [MASK_SEG-1:0] W0_mask,
    input  logic [WIDTH-1:0]    W0_data,
    input  logic                R0_en,
    input  logic [ADDR_W-1:0]   R0_addr,
    output logic [WIDTH-1:0]    R0_data,
    output logic                R0_valid
);

    if (READ_LAT != 1 && READ_LAT != 2) begin : g_bad_lat
        $error("array_mask_1r1w_ext: READ_LAT must be 1 or 2");
    end
    if (WIDTH % MASK_GRAN != 0) begin : g_bad_gran
        $error("array_mask_1r1w_ext: WIDTH must be a multiple of MASK_GRAN");
    end

    // One extra bit so DEPTH itself is representable for range checks.
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic             wr_hit;
    logic             wr_en;
    logic             rd_hit;
    logic [WIDTH-1:0] wr_word_d;
    logic [WIDTH-1:0] rd_word;

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_data_q,  s1_data_d;

    always_comb begin
        wr_hit    = W0_en && ({1'b0, W0_addr} < DEPTH_L);
        rd_hit    = R0_en && ({1'b0, R0_addr} < DEPTH_L);
        wr_en     = wr_hit && reset_n;
        wr_word_d = '0;
        rd_word   = '0;
        if (wr_hit) begin
            wr_word_d = mem_q[W0_addr];
        end
        if (rd_hit) begin
            rd_word = mem_q[R0_addr];
        end
        for (int i = 0; i < MASK_SEG; i++) begin
            if (W0_mask[i]) begin
                wr_word_d[i*MASK_GRAN +: MASK_GRAN] =
                    W0_data[i*MASK_GRAN +: MASK_GRAN];
            end
        end
`ifdef ARRAY_BYPASS_EN
        // Write-first: lanes being written forward the incoming data.
        if (rd_hit && wr_hit && (W0_addr == R0_addr)) begin
            for (int i = 0; i < MASK_SEG; i++) begin
                if (W0_mask[i]) begin
                    rd_word[i*MASK_GRAN +: MASK_GRAN] =
                        W0_data[i*MASK_GRAN +: MASK_GRAN];
                end
            end
        end
`endif
    end

    // Contents are never reset; writes are blocked while reset is held.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_q[W0_addr] <= wr_word_d;
        end
    end

    // Out-of-range reads still retire, with rd_word left at zero.
    always_comb begin
        s1_valid_d = R0_en;
        s1_data_d  = R0_en ? rd_word : s1_data_q;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
        end
    end

    if (READ_LAT == 2) begin : g_lat2
        logic             s2_valid_q, s2_valid_d;
        logic [WIDTH-1:0] s2_data_q,  s2_data_d;

        always_comb begin
            s2_valid_d = s1_valid_q;
            s2_data_d  = s1_valid_q ? s1_data_q : s2_data_q;
        end

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                s2_valid_q <= 1'b0;
                s2_data_q  <= '0;
            end else begin
                s2_valid_q <= s2_valid_d;
                s2_data_q  <= s2_data_d;
            end
        end

        assign R0_data  = s2_data_q;
        assign R0_valid = s2_valid_q;
    end else begin : g_lat1
        assign R0_data  = s1_data_q;
        assign R0_valid = s1_valid_q;
    end

endmodule

// File: tb/tb_array_mask_1r1w_ext.sv
// tb_array_mask_1r1w_ext: randomized + directed bench for two instances,
// A = defaults (DEPTH 8, READ_LAT 1), B = DEPTH 6, READ_LAT 2.
module tb_array_mask_1r1w_ext;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        W0_en = 1'b0;
    logic [2:0]  W0_addr = '0;
    logic [1:0]  W0_mask = '0;
    logic [29:0] W0_data = '0;
    logic        R0_en = 1'b0;
    logic [2:0]  R0_addr = '0;
    logic [29:0] r_data_a, r_data_b;
    logic        r_valid_a, r_valid_b;

    int n_checks = 0;
    int n_errors = 0;
    int edge_n = 0;

    always #5 clock = ~clock;

    array_mask_1r1w_ext dut_a (
        .clock(clock), .reset_n(reset_n),
        .W0_en(W0_en), .W0_addr(W0_addr),
        .W0_mask(W0_mask), .W0_data(W0_data),
        .R0_en(R0_en), .R0_addr(R0_addr),
        .R0_data(r_data_a), .R0_valid(r_valid_a)
    );

    array_mask_1r1w_ext #(.DEPTH(6), .READ_LAT(2)) dut_b (
        .clock(clock), .reset_n(reset_n),
        .W0_en(W0_en), .W0_addr(W0_addr),
        .W0_mask(W0_mask), .W0_data(W0_data),
        .R0_en(R0_en), .R0_addr(R0_addr),
        .R0_data(r_data_b), .R0_valid(r_valid_b)
    );

    // ---------------- behavioural model ----------------
    typedef struct {
        int          due;
        logic [29:0] d;
    } ent_t;

    logic [29:0] mem_a [8];
    logic [29:0] mem_b [6];
    ent_t        q_a[$];
    ent_t        q_b[$];
    logic [29:0] held_a = '0;
    logic [29:0] held_b = '0;

    function automatic logic [29:0] merge(input logic [29:0] old,
                                          input logic [1:0] m,
                                          input logic [29:0] d);
        logic [29:0] r;
        r = old;
        for (int i = 0; i < 2; i++)
            if (m[i]) r[i*15 +: 15] = d[i*15 +: 15];
        return r;
    endfunction

    function automatic logic [29:0] rd_val(input logic [29:0] stored,
                                           input bit in_range);
        logic [29:0] v;
        v = in_range ? stored : 30'd0;
`ifdef ARRAY_BYPASS_EN
        if (in_range && W0_en && W0_addr == R0_addr)
            v = merge(v, W0_mask, W0_data);
`endif
        return v;
    endfunction

    task automatic chk(input string nm, input logic [29:0] act,
                       input logic [29:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(negedge reset_n) begin
        q_a.delete();
        q_b.delete();
        held_a = '0;
        held_b = '0;
    end

    always @(posedge clock) begin
        logic ev;
        edge_n++;
        if (reset_n) begin
            if (R0_en) begin
                q_a.push_back('{edge_n, rd_val(mem_a[R0_addr], 1'b1)});
                q_b.push_back('{edge_n + 1,
                    rd_val(R0_addr < 6 ? mem_b[R0_addr] : 30'd0, R0_addr < 6)});
            end
            if (W0_en) begin
                mem_a[W0_addr] = merge(mem_a[W0_addr], W0_mask, W0_data);
                if (W0_addr < 6)
                    mem_b[W0_addr] = merge(mem_b[W0_addr], W0_mask, W0_data);
            end
        end
        #1;
        ev = 1'b0;
        if (q_a.size() > 0 && q_a[0].due == edge_n) begin
            ev = 1'b1;
            held_a = q_a[0].d;
            void'(q_a.pop_front());
        end
        chk("a_valid", {29'd0, r_valid_a}, {29'd0, ev});
        chk("a_data", r_data_a, held_a);
        ev = 1'b0;
        if (q_b.size() > 0 && q_b[0].due == edge_n) begin
            ev = 1'b1;
            held_b = q_b[0].d;
            void'(q_b.pop_front());
        end
        chk("b_valid", {29'd0, r_valid_b}, {29'd0, ev});
        chk("b_data", r_data_b, held_b);
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic wr(input logic [2:0] a, input logic [29:0] d,
                      input logic [1:0] m);
        W0_en = 1'b1; W0_addr = a; W0_data = d; W0_mask = m;
    endtask

    task automatic rd(input logic [2:0] a);
        R0_en = 1'b1; R0_addr = a;
    endtask

    task automatic idle();
        W0_en = 1'b0; R0_en = 1'b0;
    endtask

    initial begin
        repeat (3) tick();
        chk("rst_a_data", r_data_a, 30'd0);
        chk("rst_b_valid", {29'd0, r_valid_b}, 30'd0);
        reset_n = 1'b1;

        // Preload value = addr.
        for (int a = 0; a < 8; a++) begin
            wr(3'(a), 30'(a), 2'b11);
            tick();
        end
        idle();

        // Back-to-back reads; B retires two edges later, addr 6,7 read 0.
        for (int i = 0; i <= 8; i++) begin
            if (i < 8) rd(3'(i)); else idle();
            tick();
            if (i >= 1) begin
                chk("b2b_valid", {29'd0, r_valid_b}, 30'd1);
                chk("b2b_data", r_data_b, (i - 1 < 6) ? 30'(i - 1) : 30'd0);
            end
        end
        tick();
        chk("b2b_end", {29'd0, r_valid_b}, 30'd0);

        // Masked write.
        wr(3'd3, 30'h3FFFFFFF, 2'b11); tick();
        wr(3'd3, 30'h0, 2'b01); tick();
        idle(); rd(3'd3); tick();
        idle();
        chk("mask_a", r_data_a, 30'h3FFF8000);
        chk("mask_a_v", {29'd0, r_valid_a}, 30'd1);
        tick();
        chk("mask_b", r_data_b, 30'h3FFF8000);

        // Hold.
        repeat (10) tick();
        chk("hold_a", r_data_a, 30'h3FFF8000);
        chk("hold_a_v", {29'd0, r_valid_a}, 30'd0);

        // Collision.
        wr(3'd5, 30'h12345678, 2'b11); tick();
        wr(3'd5, 30'h3FFFFFFF, 2'b10); rd(3'd5); tick();
        idle();
`ifdef ARRAY_BYPASS_EN
        chk("coll_a", r_data_a, 30'h3FFFD678);
`else
        chk("coll_a", r_data_a, 30'h12345678);
`endif
        rd(3'd5); tick();
        idle();
        chk("coll_after", r_data_a, 30'h3FFFD678);

        // Out of range on B (DEPTH 6).
        wr(3'd7, 30'h2AAAAAAA, 2'b11); tick();
        idle(); rd(3'd7); tick();
        idle();
        chk("oor_a", r_data_a, 30'h2AAAAAAA);
        tick();
        chk("oor_b", r_data_b, 30'd0);
        chk("oor_b_v", {29'd0, r_valid_b}, 30'd1);

        // Reset while a B read is in flight.
        rd(3'd3); tick();
        idle();
        #1 reset_n = 1'b0;
        #1;
        chk("arst_b", r_data_b, 30'd0);
        chk("arst_b_v", {29'd0, r_valid_b}, 30'd0);
        chk("arst_a", r_data_a, 30'd0);
        tick();
        reset_n = 1'b1;
        repeat (3) tick();
        chk("post_rst_v", {29'd0, r_valid_b}, 30'd0);
        rd(3'd3); tick();
        idle(); tick();
        chk("keep_b", r_data_b, 30'h3FFF8000);

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            W0_en   = 1'($urandom_range(0, 1));
            W0_addr = 3'($urandom);
            W0_mask = 2'($urandom);
            W0_data = 30'($urandom);
            R0_en   = 1'($urandom_range(0, 1));
            R0_addr = ($urandom_range(0, 3) == 0) ? W0_addr : 3'($urandom);
            tick();
        end
        idle();
        repeat (4) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/array_mask_1r1w_ext.md
# array_mask_1r1w_ext

Parametrised masked SRAM model with one write port and one read port. It sits on the same single clock as the single-port masked array generators and is used where the design needs a simultaneous read and write each cycle. It adds depth, width and mask-granularity parameters, a configurable read latency (1 or 2), a registered read-valid, hold-last read data and a defined read/write collision policy. Storage is behavioural flops or a macro stand-in; contents are not reset.

## Interface
- DEPTH, 8: number of entries; any value ≥ 2, need not be a power of two.
- WIDTH, 30: data bits per entry.
- MASK_GRAN, 15: bits per write-mask lane; WIDTH must be a multiple of MASK_GRAN; MASK_SEG = WIDTH/MASK_GRAN.
- READ_LAT, 1: read latency in cycles; legal values 1 or 2. Any other value is a `$error` at elaboration.
- Local: ADDR_W = max(1, clog2(DEPTH)).

Ports:
- clock  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- W0_en  in  1  write enable.
- W0_addr  in  ADDR_W  write address.
- W0_mask  in  MASK_SEG  per-lane write enable; bit i covers data bits [i*MASK_GRAN +: MASK_GRAN].
- W0_data  in  WIDTH  write data.
- R0_en  in  1  read enable.
- R0_addr  in  ADDR_W  read address.
- R0_data  out  WIDTH  read data; holds the last read result.
- R0_valid  out  1  one-cycle pulse when R0_data carries a new result.

## Operation
- **Write:** at a rising edge with W0_en=1 and W0_addr<DEPTH, each lane i with W0_mask[i]=1 is written. Lanes with mask 0 keep their contents. W0_mask=0 writes nothing.
- **Out-of-range access:** a write with address ≥ DEPTH is ignored. A read with address ≥ DEPTH returns all-zero data, and R0_valid still pulses.
- **Read:** R0_en and R0_addr are sampled at a rising edge.
  - READ_LAT=1: result registered into R0_data at that edge.
  - READ_LAT=2: result passes through one extra pipeline register.
- **Read pipeline:** fully pipelined; back-to-back reads every cycle are accepted. R0_data and R0_valid change only when a result retires.
- **Idle read port:** R0_data holds its value while no read retires. It never shows garbage.
- **Collision** (R0_en, W0_en, same in-range address, same edge): resolved per lane by ARRAY_BYPASS_EN (see Configuration).
- **Reset (reset_n=0, asynchronous):**
  - R0_data=0, R0_valid=0, all pipeline valid bits cleared.
  - In-flight reads are dropped and produce no R0_valid after reset release.
  - Array contents are untouched.
  - Writes and reads are ignored while reset_n=0.
- **No state machine beyond the read pipeline.** The stages are valid+data registers: s1 (and s2 when READ_LAT=2).

## Timing
- Write occurs at edge T. A read of that address sampled at edge T+1 or later returns the new data.
- READ_LAT=1: read sampled at edge T → R0_valid=1 and R0_data valid from T until T+1 (cycle after the edge).
- READ_LAT=2: read sampled at edge T → R0_valid=1 in the cycle after edge T+1.
- R0_valid is high for exactly one cycle per accepted read.
- Continuous reads give continuous R0_valid high.
- The array read happens at the sampling edge. A write at edge T+1 does not alter a read already sampled at edge T, for either latency.
- Reset is asserted asynchronously and released synchronously by the system. The first read can be sampled at the first edge with reset_n=1.

## Configuration
- **ARRAY_BYPASS_EN defined:** write-first on collision. Lanes with W0_mask[i]=1 return W0_data. Lanes with mask 0 return the stored data.
- **ARRAY_BYPASS_EN undefined:** read-first on collision. All lanes return the pre-write contents, and the write still completes.
- Non-colliding behaviour is identical in both builds.

## Test plan
All scenarios use defaults (DEPTH=8, WIDTH=30, MASK_GRAN=15) unless stated.
- **Masked write:** write addr 3 data 0x3FFFFFFF mask 2'b11, then data 0 mask 2'b01, then read addr 3 → R0_data=0x3FFF8000 with one R0_valid pulse 1 cycle after sampling (READ_LAT=1).
- **Read latency 2:** READ_LAT=2, back-to-back reads of addrs 0..7 preloaded with value=addr → R0_valid high for 8 consecutive cycles starting 2 cycles after the first sample; data 0..7 in order.
- **Collision:**
  - Setup: addr 5 holds 0x12345678; same edge write 0x3FFFFFFF mask 2'b10 and read addr 5.
  - ARRAY_BYPASS_EN defined → R0_data=0x3FFFD678.
  - ARRAY_BYPASS_EN undefined → 0x12345678; a following read returns 0x3FFFD678.
- **Hold and out-of-range:**
  - Idle 10 cycles after a read → R0_data unchanged, R0_valid=0.
  - DEPTH=6: write addr 7 is ignored; read addr 7 → R0_data=0 with R0_valid=1.
- **Reset mid-read:** READ_LAT=2, pulse reset_n low between sampling and retirement → R0_data=0 and R0_valid=0 immediately; no valid after release; array contents preserved on a later read.
